// File: rtl/ram_bist_pkg.sv
// Shared types and the March C- element table for the RAM BIST initiator.
package ram_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int         ELEM_CNT  = 6;
  localparam logic [2:0] LAST_ELEM = 3'(ELEM_CNT - 1);

  typedef struct packed {
    logic dir_down;  // 1: walk DEPTH-1 down to 0
    logic rd_en;
    logic rd_bit;    // expected value, replicated across the word
    logic wr_en;
    logic wr_bit;    // written value, replicated across the word
  } march_t;

  // March C-: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) down(r0)
  localparam march_t MARCH_TBL [ELEM_CNT] = '{
    '{dir_down: 1'b0, rd_en: 1'b0, rd_bit: 1'b0, wr_en: 1'b1, wr_bit: 1'b0},
    '{dir_down: 1'b0, rd_en: 1'b1, rd_bit: 1'b0, wr_en: 1'b1, wr_bit: 1'b1},
    '{dir_down: 1'b0, rd_en: 1'b1, rd_bit: 1'b1, wr_en: 1'b1, wr_bit: 1'b0},
    '{dir_down: 1'b1, rd_en: 1'b1, rd_bit: 1'b0, wr_en: 1'b1, wr_bit: 1'b1},
    '{dir_down: 1'b1, rd_en: 1'b1, rd_bit: 1'b1, wr_en: 1'b1, wr_bit: 1'b0},
    '{dir_down: 1'b1, rd_en: 1'b1, rd_bit: 1'b0, wr_en: 1'b0, wr_bit: 1'b0}
  };

endpackage

// File: rtl/bist_addr_counter.sv
// Up/down address counter with parallel load; it parks at the terminal
// address instead of wrapping, so DEPTH need not be a power of two.
module bist_addr_counter #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  input  logic          i_Load,
  input  logic [AW-1:0] i_Load_Val,
  input  logic          i_En,
  input  logic          i_Down,
  output logic [AW-1:0] o_Addr,
  output logic          o_Term
);

  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

  logic [AW-1:0] r_Addr;

  assign o_Addr = r_Addr;
  assign o_Term = i_Down ? (r_Addr == '0) : (r_Addr == ADDR_LAST);

  // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Addr <= '0;
    end else if (i_Load) begin
      r_Addr <= i_Load_Val;
    end else if (i_En && !o_Term) begin
      r_Addr <= i_Down ? r_Addr - 1'b1 : r_Addr + 1'b1;
    end
  end

endmodule

// File: rtl/ram_march_bist.sv
// March C- BIST initiator: port A writes, port B reads back one cycle later;
// the first mismatch aborts the run and is captured for software.
module ram_march_bist
  import ram_bist_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst,
  input  logic                     i_Start,
  output logic                     o_Busy,
  output logic                     o_Done,
  output logic                     o_Pass,
  output logic [$clog2(DEPTH)-1:0] o_Fail_Addr,
  output logic [2:0]               o_Fail_Elem,
  output logic [WIDTH-1:0]         o_Fail_Data,
  output logic [$clog2(DEPTH)-1:0] o_PortA_Addr,
  output logic [WIDTH-1:0]         o_PortA_Data,
  output logic                     o_PortA_WE,
  output logic [$clog2(DEPTH)-1:0] o_PortB_Addr,
  input  logic [WIDTH-1:0]         i_PortB_Data
);

  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

  state_t           r_State;
  logic [2:0]       r_Elem;
  logic             r_Pass;
  logic [AW-1:0]    r_Fail_Addr;
  logic [2:0]       r_Fail_Elem;
  logic [WIDTH-1:0] r_Fail_Data;

  logic             r_Cmp_Valid;
  logic [WIDTH-1:0] r_Cmp_Exp;
  logic [AW-1:0]    r_Cmp_Addr;
  logic [2:0]       r_Cmp_Elem;

  logic [AW-1:0]    w_Addr;
  logic             w_Term;
  march_t           w_Entry;
  march_t           w_Next_Entry;
  logic [2:0]       w_Next_Elem;
  logic             w_Run;
  logic             w_Start_Go;
  logic             w_Mismatch;
  logic             w_Advance;
  logic             w_Load;
  logic [AW-1:0]    w_Load_Val;

  assign w_Entry      = MARCH_TBL[r_Elem];
  assign w_Next_Elem  = (r_Elem == LAST_ELEM) ? r_Elem : r_Elem + 3'd1;
  assign w_Next_Entry = MARCH_TBL[w_Next_Elem];

  assign w_Run      = (r_State == ST_RUN);
  assign w_Start_Go = (r_State == ST_IDLE) && i_Start;
  assign w_Mismatch = r_Cmp_Valid && (i_PortB_Data != r_Cmp_Exp);
  assign w_Advance  = w_Run && !w_Mismatch;

  // Reload at each element boundary so the next element starts without a gap cycle
  assign w_Load     = w_Start_Go || (w_Advance && w_Term && (r_Elem != LAST_ELEM));
  assign w_Load_Val = (!w_Start_Go && w_Next_Entry.dir_down) ? ADDR_LAST : '0;

  bist_addr_counter #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_addr_counter (
    .i_Clk      (i_Clk),
    .i_Rst      (i_Rst),
    .i_Load     (w_Load),
    .i_Load_Val (w_Load_Val),
    .i_En       (w_Advance),
    .i_Down     (w_Entry.dir_down),
    .o_Addr     (w_Addr),
    .o_Term     (w_Term)
  );

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State     <= ST_IDLE;
      r_Elem      <= '0;
      r_Pass      <= 1'b0;
      r_Fail_Addr <= '0;
      r_Fail_Elem <= '0;
      r_Fail_Data <= '0;
    end else begin
      case (r_State)
        ST_IDLE: begin
          if (i_Start) begin
            r_State     <= ST_RUN;
            r_Elem      <= '0;
            r_Pass      <= 1'b0;
            r_Fail_Addr <= '0;
            r_Fail_Elem <= '0;
            r_Fail_Data <= '0;
          end
        end
        ST_RUN: begin
          if (w_Mismatch) begin
            r_State     <= ST_DONE;
            r_Fail_Addr <= r_Cmp_Addr;
            r_Fail_Elem <= r_Cmp_Elem;
            r_Fail_Data <= i_PortB_Data;
          end else if (w_Term) begin
            if (r_Elem == LAST_ELEM) begin
              r_State <= ST_CHECK;
            end else begin
              r_Elem <= r_Elem + 3'd1;
            end
          end
        end
        ST_CHECK: begin
          r_State <= ST_DONE;
          if (w_Mismatch) begin
            r_Fail_Addr <= r_Cmp_Addr;
            r_Fail_Elem <= r_Cmp_Elem;
            r_Fail_Data <= i_PortB_Data;
          end else begin
            r_Pass <= 1'b1;
          end
        end
        ST_DONE: r_State <= ST_IDLE;
        default: r_State <= ST_IDLE;
      endcase
    end
  end

  // Expected value travels alongside the registered RAM read latency
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Cmp_Valid <= 1'b0;
      r_Cmp_Exp   <= '0;
      r_Cmp_Addr  <= '0;
      r_Cmp_Elem  <= '0;
    end else begin
      r_Cmp_Valid <= w_Advance && w_Entry.rd_en;
      r_Cmp_Exp   <= {WIDTH{w_Entry.rd_bit}};
      r_Cmp_Addr  <= w_Addr;
      r_Cmp_Elem  <= r_Elem;
    end
  end

  assign o_Busy       = w_Run || (r_State == ST_CHECK);
  assign o_Done       = (r_State == ST_DONE);
  assign o_Pass       = r_Pass;
  assign o_Fail_Addr  = r_Fail_Addr;
  assign o_Fail_Elem  = r_Fail_Elem;
  assign o_Fail_Data  = r_Fail_Data;
  assign o_PortA_Addr = w_Addr;
  assign o_PortA_Data = w_Run ? {WIDTH{w_Entry.wr_bit}} : '0;
  assign o_PortA_WE   = w_Advance && w_Entry.wr_en;
  assign o_PortB_Addr = w_Addr;

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: behavioural read-before-write RAMs with an
// injectable port-B stuck-at fault, and a scoreboard of expected end results.
module tb_ram_march_bist;

  typedef struct {
    string tag;
    bit    dut5;
    int    done_cyc;
    bit    pass;
    int    addr;
    int    elem;
    int    data;
  } exp_t;

  logic clk;
  logic rst;
  logic start16;
  logic start5;

  logic       d16_busy, d16_done, d16_pass, d16_pa_we;
  logic [3:0] d16_fail_addr, d16_pa_addr, d16_pb_addr;
  logic [2:0] d16_fail_elem;
  logic [7:0] d16_fail_data, d16_pa_data, d16_pb_data;

  logic       d5_busy, d5_done, d5_pass, d5_pa_we;
  logic [2:0] d5_fail_addr, d5_pa_addr, d5_pb_addr;
  logic [2:0] d5_fail_elem;
  logic [7:0] d5_fail_data, d5_pa_data, d5_pb_data;

  logic [7:0] mem16 [16];
  logic [7:0] mem5  [5];
  logic [7:0] rd_q16, rd_q5;
  logic [3:0] rd_a16;

  bit         flt_en;
  logic [3:0] flt_addr;
  int         flt_bit;
  logic       flt_val;

  int   cyc;
  int   n_checks;
  int   n_errors;
  exp_t exp_q[$];
  int   rd_exp_q[$];
  int   rd_obs_q[$];
  bit   mon_en;
  int   we_cnt;
  int   done_cnt;
  int   max_addr5;

  ram_march_bist #(.WIDTH(8), .DEPTH(16)) u_dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Start      (start16),
    .o_Busy       (d16_busy),
    .o_Done       (d16_done),
    .o_Pass       (d16_pass),
    .o_Fail_Addr  (d16_fail_addr),
    .o_Fail_Elem  (d16_fail_elem),
    .o_Fail_Data  (d16_fail_data),
    .o_PortA_Addr (d16_pa_addr),
    .o_PortA_Data (d16_pa_data),
    .o_PortA_WE   (d16_pa_we),
    .o_PortB_Addr (d16_pb_addr),
    .i_PortB_Data (d16_pb_data)
  );

  ram_march_bist #(.WIDTH(8), .DEPTH(5)) u_dut5 (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Start      (start5),
    .o_Busy       (d5_busy),
    .o_Done       (d5_done),
    .o_Pass       (d5_pass),
    .o_Fail_Addr  (d5_fail_addr),
    .o_Fail_Elem  (d5_fail_elem),
    .o_Fail_Data  (d5_fail_data),
    .o_PortA_Addr (d5_pa_addr),
    .o_PortA_Data (d5_pa_data),
    .o_PortA_WE   (d5_pa_we),
    .o_PortB_Addr (d5_pb_addr),
    .i_PortB_Data (d5_pb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Dual-port RAMs: port B returns the value held before a same-edge port A write
  always @(posedge clk) begin
    rd_q16 <= mem16[d16_pb_addr];
    rd_a16 <= d16_pb_addr;
    if (d16_pa_we) mem16[d16_pa_addr] <= d16_pa_data;
    if (d5_pb_addr < 3'd5) rd_q5 <= mem5[d5_pb_addr];
    if (d5_pa_we && d5_pa_addr < 3'd5) mem5[d5_pa_addr] <= d5_pa_data;
  end

  always_comb begin
    d16_pb_data = rd_q16;
    if (flt_en && rd_a16 == flt_addr) d16_pb_data[flt_bit] = flt_val;
    d5_pb_data = rd_q5;
  end

  always @(negedge clk) begin
    if (d16_done) done_cnt++;
    if (mon_en) begin
      if (d16_busy) rd_obs_q.push_back(int'(d16_pb_addr));
      if (d16_pa_we) we_cnt++;
    end
    if (d5_busy) begin
      if (int'(d5_pa_addr) > max_addr5) max_addr5 = int'(d5_pa_addr);
      if (int'(d5_pb_addr) > max_addr5) max_addr5 = int'(d5_pb_addr);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cycle of an access: M0 starts in cycle 1, one address per cycle
  function automatic int access_cycle(input int depth, input int elem, input int addr);
    return 1 + elem * depth + ((elem >= 3) ? (depth - 1 - addr) : addr);
  endfunction

  task automatic push_exp(input string tag, input bit dut5, input int done_cyc,
                          input bit pass, input int addr, input int elem, input int data);
    exp_t e;
    e.tag = tag; e.dut5 = dut5; e.done_cyc = done_cyc; e.pass = pass;
    e.addr = addr; e.elem = elem; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic pulse16(input string tag, output int t0);
    @(negedge clk);
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    t0 = cyc;
    check({tag, "_busy_c1"}, d16_busy, 1'b1);
    check({tag, "_pass_clr"}, d16_pass, 1'b0);
  endtask

  task automatic wait_done(input bit dut5, input int t0, output int got);
    got = -1;
    for (int g = 0; g < 400; g++) begin
      @(negedge clk);
      if ((dut5 ? d5_done : d16_done) == 1'b1) begin
        got = cyc - t0 + 1;
        break;
      end
    end
  endtask

  task automatic score(input int got);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check({e.tag, "_done_cyc"}, got, e.done_cyc);
    if (e.dut5) begin
      check({e.tag, "_busy"}, d5_busy, 1'b0);
      check({e.tag, "_pass"}, d5_pass, e.pass);
      check({e.tag, "_faddr"}, d5_fail_addr, e.addr);
      check({e.tag, "_felem"}, d5_fail_elem, e.elem);
      check({e.tag, "_fdata"}, d5_fail_data, e.data);
    end else begin
      check({e.tag, "_busy"}, d16_busy, 1'b0);
      check({e.tag, "_pass"}, d16_pass, e.pass);
      check({e.tag, "_faddr"}, d16_fail_addr, e.addr);
      check({e.tag, "_felem"}, d16_fail_elem, e.elem);
      check({e.tag, "_fdata"}, d16_fail_data, e.data);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  d16_busy, 0);
    check({tag, "_done"},  d16_done, 0);
    check({tag, "_pass"},  d16_pass, 0);
    check({tag, "_faddr"}, d16_fail_addr, 0);
    check({tag, "_felem"}, d16_fail_elem, 0);
    check({tag, "_fdata"}, d16_fail_data, 0);
    check({tag, "_pa_we"}, d16_pa_we, 0);
    check({tag, "_pa_addr"}, d16_pa_addr, 0);
    check({tag, "_pa_data"}, d16_pa_data, 0);
    check({tag, "_pb_addr"}, d16_pb_addr, 0);
  endtask

  initial begin
    int t0;
    int got;
    int snap;
    rst = 1'b1; start16 = 1'b0; start5 = 1'b0;
    flt_en = 1'b0; flt_addr = '0; flt_bit = 0; flt_val = 1'b0;
    cyc = 0; n_checks = 0; n_errors = 0;
    mon_en = 1'b0; we_cnt = 0; done_cnt = 0; max_addr5 = 0;

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fault-free pass with port activity monitoring
    for (int e = 0; e < 6; e++)
      for (int a = 0; a < 16; a++)
        rd_exp_q.push_back((e >= 3) ? 15 - a : a);
    push_exp("pass", 1'b0, 6 * 16 + 2, 1'b1, 0, 0, 0);
    mon_en = 1'b1;
    pulse16("pass", t0);
    wait_done(1'b0, t0, got);
    mon_en = 1'b0;
    score(got);
    check("pass_we_cnt", we_cnt, 80);
    check("pass_rd_len", rd_obs_q.size(), 97);
    for (int i = 0; i < 96 && i < rd_obs_q.size(); i++)
      check($sformatf("pass_rd%0d", i), rd_obs_q[i], rd_exp_q[i]);

    // Bit 3 stuck-at-1 at address 5: caught by the first M1 read there
    flt_en = 1'b1; flt_addr = 4'd5; flt_bit = 3; flt_val = 1'b1;
    push_exp("sa1", 1'b0, access_cycle(16, 1, 5) + 2, 1'b0, 5, 1, 8'h08);
    pulse16("sa1", t0);
    wait_done(1'b0, t0, got);
    score(got);

    // Bit 0 stuck-at-0 at address 15: invisible until a "1" is read back in M2
    flt_addr = 4'd15; flt_bit = 0; flt_val = 1'b0;
    push_exp("sa0", 1'b0, access_cycle(16, 2, 15) + 2, 1'b0, 15, 2, 8'hFE);
    pulse16("sa0", t0);
    wait_done(1'b0, t0, got);
    score(got);
    flt_en = 1'b0;

    // Reset in cycle 40 of a run
    pulse16("rst", t0);
    repeat (39) @(negedge clk);
    snap = done_cnt;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_no_done", done_cnt, snap);
    check("midrst_idle", d16_busy, 0);
    push_exp("after_rst", 1'b0, 98, 1'b1, 0, 0, 0);
    pulse16("after_rst", t0);
    wait_done(1'b0, t0, got);
    score(got);

    // Start re-pulsed while busy
    push_exp("repulse", 1'b0, 98, 1'b1, 0, 0, 0);
    pulse16("repulse", t0);
    repeat (49) @(negedge clk);
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    wait_done(1'b0, t0, got);
    score(got);

    // Start held high: back-to-back runs, second done 99 cycles after the first
    push_exp("held1", 1'b0, 98, 1'b1, 0, 0, 0);
    push_exp("held2", 1'b0, 98 + 99, 1'b1, 0, 0, 0);
    @(negedge clk);
    start16 = 1'b1;
    @(negedge clk);
    t0 = cyc;
    wait_done(1'b0, t0, got);
    score(got);
    wait_done(1'b0, t0, got);
    start16 = 1'b0;
    score(got);
    repeat (3) @(negedge clk);
    check("held_stop", d16_busy, 0);

    // Non-power-of-two depth
    push_exp("d5", 1'b1, 6 * 5 + 2, 1'b1, 0, 0, 0);
    @(negedge clk);
    start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    t0 = cyc;
    check("d5_busy_c1", d5_busy, 1'b1);
    wait_done(1'b1, t0, got);
    score(got);
    check("d5_max_addr", max_addr5, 4);
    check("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
